// File: rtl/cmip_fifo_burst_reader_pkg.sv
// Shared types and constants for the FIFO burst reader and its skid buffer.
package cmip_fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    localparam int SKID_DPTH = 2;
    localparam int OCC_WDTH  = $clog2(SKID_DPTH + 1);

endpackage

// File: rtl/cmip_fifo_burst_reader_skid.sv
// Two-entry valid/ready buffer; entry 0 always drives the output, entry 1 catches overflow.
module cmip_skid_buf_2e
    import cmip_fifo_rd_pkg::*;
#(
    parameter int WDTH = 514
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_push,
    input  logic [WDTH-1:0]     i_data,
    output logic                o_vld,
    output logic [WDTH-1:0]     o_data,
    input  logic                i_rdy,
    output logic [OCC_WDTH-1:0] o_occ
);

    logic [WDTH-1:0]     ent0_q, ent0_d;
    logic [WDTH-1:0]     ent1_q, ent1_d;
    logic [OCC_WDTH-1:0] occ_q, occ_d;
    logic [OCC_WDTH-1:0] wr_idx;
    logic                pop;
    logic                push_ok;

    always_comb begin
        pop     = (occ_q != '0) && i_rdy;
        wr_idx  = occ_q - OCC_WDTH'(pop);
        push_ok = i_push && (wr_idx < OCC_WDTH'(SKID_DPTH));
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (pop) begin
            ent0_d = ent1_q;
        end
        // A push lands in the slot that is free after this cycle's pop.
        if (push_ok) begin
            if (wr_idx == '0) begin
                ent0_d = i_data;
            end else begin
                ent1_d = i_data;
            end
        end
        occ_d = occ_q - OCC_WDTH'(pop) + OCC_WDTH'(push_ok);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign o_vld  = (occ_q != '0);
    assign o_data = ent0_q;
    assign o_occ  = occ_q;

endmodule

// File: rtl/cmip_fifo_burst_reader.sv
// Pops whole bursts (or a flushed partial) from a 1-cycle-latency FIFO and streams them out
// with sop/eop markers; reads are throttled so the skid buffer can always take the returning word.
module cmip_fifo_burst_reader
    import cmip_fifo_rd_pkg::*;
#(
    parameter int DPTH      = 32,
    parameter int DATA_WDTH = 512,
    parameter int ADDR_WDTH = $clog2(DPTH),
    parameter int CNT_WDTH  = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [ADDR_WDTH:0]   i_burst_len,
    input  logic                 i_flush,
    output logic                 o_fifo_rd,
    input  logic [DATA_WDTH-1:0] i_fifo_dout,
    input  logic                 i_fifo_empty,
    input  logic [ADDR_WDTH:0]   i_fifo_rd_cnt,
    output logic                 o_vld,
    output logic [DATA_WDTH-1:0] o_data,
    output logic                 o_sop,
    output logic                 o_eop,
    input  logic                 i_rdy,
    output logic                 o_busy,
    output logic                 o_burst_done,
    output logic                 o_unfl_int,
    output logic [CNT_WDTH-1:0]  o_burst_cnt
);

    localparam int                 SKW    = DATA_WDTH + 2;
    localparam logic [ADDR_WDTH:0] DPTH_V = (ADDR_WDTH + 1)'(DPTH);
    localparam logic [ADDR_WDTH:0] ONE_V  = (ADDR_WDTH + 1)'(1);

    rd_state_e           state_q;
    logic [ADDR_WDTH:0]  rem_q;
    logic                sop_pend_q;
    logic                infl_q, infl_sop_q, infl_eop_q;
    logic                unfl_seen_q, unfl_int_q;
    logic [CNT_WDTH-1:0] burst_cnt_q;

    logic [ADDR_WDTH:0]  len_clamped;
    logic                start_full, start_flush;
    logic                skid_vld, skid_pop, burst_done, rd_room, fifo_rd, unfl_hit;
    logic [SKW-1:0]      skid_data;
    logic [OCC_WDTH-1:0] skid_occ, occ_ahead;

    always_comb begin
        len_clamped = (i_burst_len > DPTH_V) ? DPTH_V : i_burst_len;
        start_full  = i_en && (i_burst_len != '0) && (i_fifo_rd_cnt >= len_clamped);
        start_flush = i_en && i_flush && (i_fifo_rd_cnt != '0);
        skid_pop    = skid_vld && i_rdy;
        burst_done  = skid_pop && skid_data[0];
        // Room is judged after this cycle's pop so a steady stream reads every cycle.
        occ_ahead   = skid_occ - OCC_WDTH'(skid_pop) + OCC_WDTH'(infl_q);
        rd_room     = (state_q == ST_READ) && (rem_q != '0) && (occ_ahead < OCC_WDTH'(SKID_DPTH));
        fifo_rd     = rd_room && !i_fifo_empty && i_rst_n;
        unfl_hit    = rd_room && i_fifo_empty && !unfl_seen_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            sop_pend_q  <= 1'b0;
            infl_q      <= 1'b0;
            infl_sop_q  <= 1'b0;
            infl_eop_q  <= 1'b0;
            unfl_seen_q <= 1'b0;
            unfl_int_q  <= 1'b0;
            burst_cnt_q <= '0;
        end else begin
            infl_q     <= fifo_rd;
            infl_sop_q <= sop_pend_q;
            infl_eop_q <= (rem_q == ONE_V);
            unfl_int_q <= unfl_hit;
            if (burst_done) begin
                burst_cnt_q <= burst_cnt_q + CNT_WDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_full) begin
                        rem_q       <= len_clamped;
                        sop_pend_q  <= 1'b1;
                        unfl_seen_q <= 1'b0;
                        state_q     <= ST_READ;
                    end else if (start_flush) begin
                        rem_q       <= i_fifo_rd_cnt;
                        sop_pend_q  <= 1'b1;
                        unfl_seen_q <= 1'b0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (unfl_hit) begin
                        unfl_seen_q <= 1'b1;
                    end
                    if (fifo_rd) begin
                        rem_q      <= rem_q - ONE_V;
                        sop_pend_q <= 1'b0;
                        if (rem_q == ONE_V) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (burst_done || ((skid_occ == '0) && !infl_q)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    cmip_skid_buf_2e #(
        .WDTH (SKW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (infl_q),
        .i_data  ({i_fifo_dout, infl_sop_q, infl_eop_q}),
        .o_vld   (skid_vld),
        .o_data  (skid_data),
        .i_rdy   (i_rdy),
        .o_occ   (skid_occ)
    );

    assign o_fifo_rd    = fifo_rd;
    assign o_vld        = skid_vld;
    assign o_data       = skid_data[SKW-1:2];
    assign o_sop        = skid_data[1];
    assign o_eop        = skid_data[0];
    assign o_busy       = (state_q != ST_IDLE);
    assign o_burst_done = burst_done;
    assign o_unfl_int   = unfl_int_q;
    assign o_burst_cnt  = burst_cnt_q;

endmodule

// File: tb/tb_cmip_fifo_burst_reader.sv
// Directed bench: FIFO model with 1-cycle read latency, per-burst vector table, and
// hand-written underflow and mid-burst reset sequences.
module tb_cmip_fifo_burst_reader;

    localparam int DPTH = 32;
    localparam int DW   = 16;
    localparam int AW   = $clog2(DPTH);
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          rst_n, en, flush, fifo_rd, fifo_empty, vld, sop, eop, rdy, busy, done, unfl;
    logic [AW:0]   burst_len, rd_cnt;
    logic [DW-1:0] fifo_dout, data;
    logic [CW-1:0] bcnt;

    always #5 clk = ~clk;

    cmip_fifo_burst_reader #(
        .DPTH(DPTH), .DATA_WDTH(DW), .ADDR_WDTH(AW), .CNT_WDTH(CW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_burst_len(burst_len), .i_flush(flush),
        .o_fifo_rd(fifo_rd), .i_fifo_dout(fifo_dout), .i_fifo_empty(fifo_empty),
        .i_fifo_rd_cnt(rd_cnt), .o_vld(vld), .o_data(data), .o_sop(sop), .o_eop(eop),
        .i_rdy(rdy), .o_busy(busy), .o_burst_done(done), .o_unfl_int(unfl), .o_burst_cnt(bcnt)
    );

    typedef struct {
        int len;
        bit flush;
        int preload;
        int base;
        bit tog;
        int exp_words;
    } vec_t;

    vec_t          vecs[7];
    int            errors = 0;
    int            checks = 0;
    logic [DW+1:0] exp_q[$];
    logic [DW-1:0] fifo_q[$];
    bit            force_empty;
    int            cycle_no, rd_n, acc_n, vld_n, done_n, unfl_n, first_rd, last_rd, first_vld;
    int            exp_bursts, start_cycle;
    bit            prev_vld, prev_hs;
    logic [DW+1:0] prev_word;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cycle_no);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fifo_q.size() == 0) || force_empty;
        rd_cnt     = (AW + 1)'(fifo_q.size());
    endtask

    task automatic clear_stats();
        rd_n = 0; acc_n = 0; vld_n = 0; done_n = 0; unfl_n = 0;
        first_rd = -1; last_rd = -1; first_vld = -1;
        prev_vld = 1'b0; prev_hs = 1'b0; prev_word = '0;
    endtask

    task automatic preload(input int base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(DW'(base + i));
        fifo_sync();
    endtask

    task automatic push_exp(input int base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({DW'(base + i), (i == 0), (i == n - 1)});
    endtask

    // One clock: sample at negedge, advance, then update the FIFO model #1 after the edge.
    task automatic cyc();
        bit            rd_s;
        logic [DW+1:0] w;
        @(negedge clk);
        rd_s = fifo_rd;
        w    = {data, sop, eop};
        if (rd_s) begin
            chk("rd_while_empty", fifo_empty, 0);
            rd_n++;
            if (first_rd < 0) first_rd = cycle_no;
            last_rd = cycle_no;
        end
        if (vld) begin
            vld_n++;
            if (first_vld < 0) first_vld = cycle_no;
        end
        if (prev_vld && !prev_hs) begin
            chk("hold_vld", vld, 1);
            chk("hold_word", w, prev_word);
        end
        if (vld && rdy) begin
            acc_n++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none (cycle %0d)", w, cycle_no);
            end else begin
                chk("stream_word", w, exp_q.pop_front());
            end
        end
        if (rd_s) chk("outstanding_le2", (rd_n - acc_n) <= 2, 1);
        if (done) begin
            done_n++;
            chk("done_with_eop", vld && rdy && eop, 1);
        end
        if (unfl) unfl_n++;
        prev_vld  = vld;
        prev_hs   = vld && rdy;
        prev_word = w;
        @(posedge clk);
        #1;
        if (rd_s) fifo_dout = (fifo_q.size() != 0) ? fifo_q.pop_front() : DW'(16'hDEAD);
        fifo_sync();
        cycle_no++;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_n == 0; k++) cyc();
        en    = 1'b0;
        flush = 1'b0;
        if (done_n == 0) chk("burst_timeout", 0, 1);
    endtask

    initial begin
        vecs[0] = '{4,  1'b0, 4,  'hA0,  1'b0, 4};
        vecs[1] = '{4,  1'b0, 4,  'hB0,  1'b1, 4};
        vecs[2] = '{8,  1'b1, 3,  'hC0,  1'b0, 3};
        vecs[3] = '{8,  1'b0, 3,  'hD0,  1'b0, 0};
        vecs[4] = '{1,  1'b0, 1,  'hE0,  1'b0, 1};
        vecs[5] = '{0,  1'b0, 2,  'hF0,  1'b0, 0};
        vecs[6] = '{40, 1'b0, 32, 'h100, 1'b0, 32};

        rst_n = 1'b0; en = 1'b0; flush = 1'b0; rdy = 1'b0; burst_len = '0;
        fifo_dout = '0; force_empty = 1'b0; cycle_no = 0; exp_bursts = 0;
        fifo_sync();
        clear_stats();
        repeat (3) cyc();
        chk("reset_outputs", {fifo_rd, vld, data, sop, eop, busy, done, unfl, bcnt}, 0);
        rst_n = 1'b1;
        cyc();

        for (int v = 0; v < 7; v++) begin
            fifo_q.delete();
            exp_q.delete();
            preload(vecs[v].base, vecs[v].preload);
            clear_stats();
            if (vecs[v].exp_words > 0) begin
                push_exp(vecs[v].base, vecs[v].exp_words);
                exp_bursts++;
            end
            burst_len   = (AW + 1)'(vecs[v].len);
            flush       = vecs[v].flush;
            en          = 1'b1;
            rdy         = 1'b1;
            start_cycle = cycle_no;
            if (vecs[v].exp_words == 0) begin
                repeat (12) cyc();
                en    = 1'b0;
                flush = 1'b0;
            end else begin
                for (int k = 0; k < 200 && done_n == 0; k++) begin
                    rdy = vecs[v].tog ? (k % 3 == 0) : 1'b1;
                    cyc();
                end
                en    = 1'b0;
                flush = 1'b0;
                if (done_n == 0) chk("burst_timeout", 0, 1);
            end
            rdy = 1'b1;
            repeat (3) cyc();
            chk("words_accepted", acc_n, vecs[v].exp_words);
            chk("fifo_reads", rd_n, vecs[v].exp_words);
            chk("done_pulses", done_n, (vecs[v].exp_words > 0) ? 1 : 0);
            chk("no_underflow", unfl_n, 0);
            chk("burst_cnt", bcnt, exp_bursts);
            chk("idle_after", busy, 0);
            chk("exp_left", exp_q.size(), 0);
            if (!vecs[v].tog && vecs[v].exp_words > 0) begin
                chk("first_vld_latency", first_vld - start_cycle, 3);
                chk("rd_consecutive", last_rd - first_rd + 1, vecs[v].exp_words);
                chk("vld_cycles", vld_n, vecs[v].exp_words);
            end
        end

        // Full burst takes priority over a simultaneous flush.
        fifo_q.delete(); exp_q.delete(); clear_stats();
        preload('h30, 6);
        push_exp('h30, 4);
        exp_bursts++;
        burst_len = (AW + 1)'(4); flush = 1'b1; en = 1'b1; rdy = 1'b1;
        wait_done(100);
        repeat (3) cyc();
        chk("prio_words", acc_n, 4);
        chk("prio_left_in_fifo", fifo_q.size(), 2);
        chk("prio_burst_cnt", bcnt, exp_bursts);

        // FIFO claims empty for 5 cycles mid-burst although the count was sufficient.
        fifo_q.delete(); exp_q.delete(); clear_stats();
        preload('h50, 4);
        push_exp('h50, 4);
        exp_bursts++;
        burst_len = (AW + 1)'(4); en = 1'b1; rdy = 1'b1;
        cyc();
        cyc();
        force_empty = 1'b1;
        fifo_sync();
        start_cycle = rd_n;
        repeat (5) cyc();
        chk("no_rd_while_forced", rd_n - start_cycle, 0);
        force_empty = 1'b0;
        fifo_sync();
        wait_done(100);
        repeat (3) cyc();
        chk("unfl_pulses", unfl_n, 1);
        chk("unfl_words", acc_n, 4);
        chk("unfl_reads", rd_n, 4);
        chk("unfl_burst_cnt", bcnt, exp_bursts);

        // Reset for one cycle while word 2 of 4 is presented.
        fifo_q.delete(); exp_q.delete(); clear_stats();
        preload('h60, 4);
        push_exp('h60, 4);
        burst_len = (AW + 1)'(4); en = 1'b1; rdy = 1'b1;
        repeat (5) cyc();
        chk("pre_reset_accepted", acc_n, 2);
        rst_n = 1'b0; rdy = 1'b0; en = 1'b0;
        cyc();
        rst_n = 1'b1;
        chk("mid_reset_outputs", {fifo_rd, vld, data, sop, eop, busy, done, unfl, bcnt}, 0);
        exp_bursts = 0;
        fifo_q.delete(); exp_q.delete(); clear_stats();
        fifo_sync();
        rdy = 1'b1;
        repeat (3) cyc();
        chk("post_reset_no_vld", vld_n, 0);
        chk("post_reset_no_rd", rd_n, 0);
        preload('h70, 4);
        push_exp('h70, 4);
        exp_bursts++;
        en = 1'b1;
        wait_done(100);
        repeat (3) cyc();
        chk("post_reset_words", acc_n, 4);
        chk("post_reset_burst_cnt", bcnt, exp_bursts);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cmip_fifo_burst_reader.md
Name: cmip_fifo_burst_reader

Overview:
- Read-side consumer for the team's async FIFO, configured in standard (non-FWFT) read mode with 1-cycle read latency; sits in the read clock domain.
- Waits until the FIFO holds a full burst, or a flush is requested, then pops exactly that many words.
- Presents the words as a valid/ready stream with start/end-of-burst markers.
- A 2-entry skid buffer absorbs the FIFO read latency, so i_rdy backpressure never loses or duplicates data.

Parameters:
- DPTH, 32, depth of the upstream FIFO.
- DATA_WDTH, 512, data width.
- ADDR_WDTH, $clog2(DPTH), FIFO count/threshold width minus 1.
- CNT_WDTH, 16, width of the completed-burst counter.

Ports:
- i_clk  in  1  single clock; the FIFO read clock.
- i_rst_n  in  1  synchronous, active-low reset.
- i_en  in  1  enables starting new bursts.
- i_burst_len  in  ADDR_WDTH+1  words per burst; sampled at burst start.
- i_flush  in  1  level; drain a partial FIFO as a short burst.
- o_fifo_rd  out  1  FIFO read enable.
- i_fifo_dout  in  DATA_WDTH  FIFO data, valid the cycle after o_fifo_rd.
- i_fifo_empty  in  1  FIFO empty.
- i_fifo_rd_cnt  in  ADDR_WDTH+1  FIFO read-side count.
- o_vld  out  1  stream valid.
- o_data  out  DATA_WDTH  stream data.
- o_sop  out  1  first word of burst, qualified by o_vld.
- o_eop  out  1  last word of burst, qualified by o_vld.
- i_rdy  in  1  stream ready.
- o_busy  out  1  a burst is in progress.
- o_burst_done  out  1  one-cycle pulse when the last word is accepted.
- o_unfl_int  out  1  one-cycle pulse on empty/count inconsistency.
- o_burst_cnt  out  CNT_WDTH  completed bursts; wraps at max.

Behaviour:
- Reset: every output is 0. State is IDLE. Skid buffer and in-flight tracking are cleared.
- Reset asserted mid-burst aborts the burst. A FIFO word whose read is already in flight is discarded, not captured.
- State machine: IDLE -> READ -> DRAIN -> IDLE.
- IDLE, start condition:
  - If i_en=1, i_burst_len!=0 and i_fifo_rd_cnt>=len, latch rem=len. len is i_burst_len clamped to DPTH.
  - Otherwise, if i_en=1, i_flush=1 and i_fifo_rd_cnt!=0, latch rem=i_fifo_rd_cnt. This is a short burst.
  - When both conditions hold, the full burst wins.
  - i_burst_len=0 with no flush: the block stays in IDLE.
- READ:
  - o_fifo_rd = !i_fifo_empty && rem!=0 && (buf_occ + inflight) < 2.
  - Each read decrements rem.
  - When the last read has been issued, go to DRAIN.
- DRAIN: when the skid buffer is empty and nothing is in flight, go to IDLE.
- o_busy is 1 in READ and DRAIN.
- Latency: o_fifo_rd in cycle T; data is captured at the end of T+1; o_vld is high in T+2. First o_vld appears 3 cycles after the start condition is seen in IDLE.
- Sustained throughput is 1 word/cycle while i_rdy=1.
- Stream rules:
  - Once o_vld is high, o_data, o_sop and o_eop hold until o_vld&&i_rdy.
  - o_vld never drops without a handshake.
  - o_sop is on the first word; o_eop is on the word whose read set rem to 0.
  - A 1-word burst has o_sop=o_eop=1.
- o_burst_done and the o_burst_cnt increment occur in the cycle the eop handshake completes. The next burst may start the following cycle.
- i_en or i_flush deasserted mid-burst has no effect; the burst completes.
- Underflow: in READ with rem!=0 and i_fifo_empty=1 while the read is otherwise permitted, o_unfl_int pulses once per burst. The block then stalls without reading and resumes when the FIFO is non-empty.
- The block never asserts o_fifo_rd while i_fifo_empty=1.

Decomposition:
- Package cmip_fifo_rd_pkg: state enum (IDLE/READ/DRAIN), SKID_DPTH=2 constant.
- Sub-module cmip_skid_buf_2e: 2-entry valid/ready buffer with occupancy output, parameterised by DATA_WDTH+2 (data, sop, eop).

Test Plan:
- Burst len=4, FIFO preloaded with 0xA0..0xA3, i_rdy=1 -> o_fifo_rd 4 consecutive cycles; o_vld 4 cycles starting 3 cycles after start; sop on 0xA0, eop on 0xA3; o_burst_done pulse; o_burst_cnt=1.
- Same burst with i_rdy toggling 1,0,0,1,... -> all 4 words delivered in order, none duplicated; o_fifo_rd never issued with buf_occ+inflight=2.
- len=8, FIFO holds 3, i_flush=1 -> 3-word burst, sop on word 0, eop on word 2; with i_flush=0 the block stays IDLE.
- len=1 -> single word with sop=eop=1; len=0 and no flush -> no reads.
- Force i_fifo_empty=1 mid-burst for 5 cycles while count was sufficient -> o_unfl_int pulses once, no reads while empty, burst completes after empty drops.
- Assert i_rst_n=0 for one cycle during word 2 of 4 -> all outputs 0 next cycle; after release with FIFO refilled, the next burst starts with a clean sop.
